// File: rtl/pc_next_unit_pkg.sv
// Shared types, defaults and mask helper for the program-counter generator.
package pc_next_unit_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned ADDR_BITS_DEF  = 31;
    localparam int unsigned RESET_VEC_DEF  = 0;
    localparam int unsigned INC_DEF        = 4;
    localparam int unsigned ALIGN_BITS_DEF = 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Ones in the low 'bits' positions; callers truncate to their own width.
    function automatic logic [63:0] low_mask(input int unsigned bits);
        if (bits >= 64) begin
            return '1;
        end
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_next_unit_target_adder.sv
// Base+offset adder with address-space masking and alignment check.
module pc_next_unit_target_adder
    import pc_next_unit_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
    parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_offset,
    output logic [XLEN-1:0] o_target_c,
    output logic            o_misalign_c
);

    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(low_mask(ADDR_BITS));
    localparam logic [XLEN-1:0] ALIGN_CLR = ~XLEN'(low_mask(ALIGN_BITS));

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_masked;

    // Sum wraps mod 2^XLEN before the unimplemented upper bits are dropped.
    always_comb begin
        w_sum        = i_base + i_offset;
        w_masked     = w_sum & ADDR_MASK;
        o_target_c   = w_masked & ALIGN_CLR;
        o_misalign_c = |(w_masked & ~ALIGN_CLR);
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch-PC generator: sequential advance, redirect, halt, with a
// valid/ready hand-off to fetch and a misaligned-target pulse.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int unsigned INC        = INC_DEF,
    parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_offset,
    output logic            redirect_ready,
    input  logic            halt_req,
    output logic            halted,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(low_mask(ADDR_BITS));
    localparam logic [XLEN-1:0] ALIGN_CLR = ~XLEN'(low_mask(ALIGN_BITS));
    localparam logic [XLEN-1:0] PC_RESET  = RESET_VEC & ADDR_MASK & ALIGN_CLR;
    localparam logic [XLEN-1:0] INC_W     = XLEN'(INC);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_halted;
    logic            r_redirect_ready;
    logic            r_misalign;

    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_pc_valid_nxt;
    logic            w_halted_nxt;
    logic            w_redirect_ready_nxt;
    logic            w_misalign_nxt;

    logic [XLEN-1:0] w_inc_target_c;
    logic            w_inc_misalign_c;
    logic [XLEN-1:0] w_redir_target_c;
    logic            w_redir_misalign_c;
    logic            w_redirect_acc;
    logic            w_advance;

    pc_next_unit_target_adder #(
        .XLEN       (XLEN),
        .ADDR_BITS  (ADDR_BITS),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_inc_adder (
        .i_base       (r_pc),
        .i_offset     (INC_W),
        .o_target_c   (w_inc_target_c),
        .o_misalign_c (w_inc_misalign_c)
    );

    pc_next_unit_target_adder #(
        .XLEN       (XLEN),
        .ADDR_BITS  (ADDR_BITS),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_redir_adder (
        .i_base       (redirect_base),
        .i_offset     (redirect_offset),
        .o_target_c   (w_redir_target_c),
        .o_misalign_c (w_redir_misalign_c)
    );

    assign w_redirect_acc = redirect_valid & r_redirect_ready;
    assign w_advance      = (r_state == ST_RUN) & r_pc_valid & fetch_ready;

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt          = r_state;
        w_pc_nxt             = r_pc;
        w_misalign_nxt       = 1'b0;

        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = halt_req ? ST_HALT : ST_RUN;
            ST_HALT: w_state_nxt = halt_req ? ST_HALT : ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase

        // Redirect wins over advance; an un-fetched pc is simply overwritten.
        if (w_redirect_acc) begin
            w_pc_nxt       = w_redir_target_c;
            w_misalign_nxt = w_redir_misalign_c;
        end else if (w_advance) begin
            w_pc_nxt = w_inc_target_c;
        end

        w_pc_valid_nxt       = (w_state_nxt == ST_RUN);
        w_halted_nxt         = (w_state_nxt == ST_HALT);
        w_redirect_ready_nxt = (w_state_nxt != ST_BOOT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_BOOT;
            r_pc             <= PC_RESET;
            r_pc_valid       <= 1'b0;
            r_halted         <= 1'b0;
            r_redirect_ready <= 1'b0;
            r_misalign       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_pc_valid       <= w_pc_valid_nxt;
            r_halted         <= w_halted_nxt;
            r_redirect_ready <= w_redirect_ready_nxt;
            r_misalign       <= w_misalign_nxt;
        end
    end

    // An aligned pc plus an aligned increment can never become misaligned.
    a_inc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        w_advance |-> !w_inc_misalign_c);

    assign pc             = r_pc;
    assign pc_valid       = r_pc_valid;
    assign halted         = r_halted;
    assign redirect_ready = r_redirect_ready;
    assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with default parameters (XLEN=32, ADDR_BITS=31).
`timescale 1ns/1ps
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic        redirect_ready;
    logic        halt_req;
    logic        halted;
    logic        misalign_err;

    int total;
    int bad;

    pc_next_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_ready     (fetch_ready),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .redirect_ready  (redirect_ready),
        .halt_req        (halt_req),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1; halt_req = 1'b0;
        redirect_valid = 1'b0; redirect_base = '0; redirect_offset = '0;
        #12;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (redirect_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", redirect_ready); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", misalign_err); end
        rst_n = 1'b1;
        #1;
        total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
                bad++; $display("FAIL seq_%0d: got pc=%h v=%b want pc=%h v=1", i, pc, pc_valid, exp_pc[i]);
            end
        end
        total++; if (redirect_ready !== 1'b1) begin bad++; $display("FAIL run_rdy: got %b want 1", redirect_ready); end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc !== 32'h8 || pc_valid !== 1'b1) begin
                bad++; $display("FAIL stall_%0d: got pc=%h v=%b want pc=00000008 v=1", i, pc, pc_valid);
            end
        end
        fetch_ready = 1'b1;
        step();
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL resume: got %h want %h", pc, 32'hC); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_base = 32'h100; redirect_offset = 32'hFFFF_FFF0;
        step();
        redirect_valid = 1'b0;
        total++; if (pc !== 32'hF0) begin bad++; $display("FAIL redir_neg_pc: got %h want %h", pc, 32'hF0); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL redir_neg_mis: got %b want 0", misalign_err); end
        total++; if (pc_valid !== 1'b1) begin bad++; $display("FAIL redir_neg_valid: got %b want 1", pc_valid); end
        redirect_valid = 1'b1; redirect_base = 32'h100; redirect_offset = 32'h6;
        step();
        redirect_valid = 1'b0;
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL redir_mis_pc: got %h want %h", pc, 32'h104); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL redir_mis_pulse: got %b want 1", misalign_err); end
        step();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL redir_mis_clear: got %b want 0", misalign_err); end
        total++; if (pc !== 32'h108) begin bad++; $display("FAIL redir_mis_next: got %h want %h", pc, 32'h108); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_base = 32'h7FFF_FFFC; redirect_offset = 32'h0;
        step();
        redirect_valid = 1'b0;
        total++; if (pc !== 32'h7FFF_FFFC) begin bad++; $display("FAIL wrap_load: got %h want %h", pc, 32'h7FFF_FFFC); end
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_adv: got %h want %h", pc, 32'h0); end
        redirect_valid = 1'b1; redirect_base = 32'hFFFF_FF00; redirect_offset = 32'h0;
        step();
        redirect_valid = 1'b0;
        total++; if (pc !== 32'h7FFF_FF00) begin bad++; $display("FAIL mask_msb: got %h want %h", pc, 32'h7FFF_FF00); end
    endtask

    task automatic test_halt_redirect();
        halt_req = 1'b1;
        redirect_valid = 1'b1; redirect_base = 32'h200; redirect_offset = 32'h0;
        step();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b1 || pc_valid !== 1'b0) begin
            bad++; $display("FAIL halt_enter: got h=%b v=%b want h=1 v=0", halted, pc_valid);
        end
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL halt_pc: got %h want %h", pc, 32'h200); end
        step();
        total++; if (halted !== 1'b1 || pc !== 32'h200) begin
            bad++; $display("FAIL halt_hold: got h=%b pc=%h want h=1 pc=00000200", halted, pc);
        end
        halt_req = 1'b0;
        step();
        total++; if (halted !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h200) begin
            bad++; $display("FAIL halt_resume: got h=%b v=%b pc=%h want h=0 v=1 pc=00000200", halted, pc_valid, pc);
        end
        step();
        total++; if (pc !== 32'h204) begin bad++; $display("FAIL halt_after: got %h want %h", pc, 32'h204); end
    endtask

    task automatic test_redirect_in_halt();
        halt_req = 1'b1;
        step();
        total++; if (halted !== 1'b1 || pc !== 32'h208) begin
            bad++; $display("FAIL hir_enter: got h=%b pc=%h want h=1 pc=00000208", halted, pc);
        end
        total++; if (redirect_ready !== 1'b1) begin bad++; $display("FAIL hir_rdy: got %b want 1", redirect_ready); end
        redirect_valid = 1'b1; redirect_base = 32'h3F0; redirect_offset = 32'h10;
        step();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h400) begin
            bad++; $display("FAIL hir_load: got h=%b v=%b pc=%h want h=1 v=0 pc=00000400", halted, pc_valid, pc);
        end
        halt_req = 1'b0;
        step();
        total++; if (pc_valid !== 1'b1 || pc !== 32'h400) begin
            bad++; $display("FAIL hir_resume: got v=%b pc=%h want v=1 pc=00000400", pc_valid, pc);
        end
    endtask

    task automatic test_reset_mid();
        step();
        total++; if (pc !== 32'h404) begin bad++; $display("FAIL mid_pre: got %h want %h", pc, 32'h404); end
        redirect_valid = 1'b1; redirect_base = 32'h500; redirect_offset = 32'h0;
        rst_n = 1'b0;
        #1;
        total++; if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect_ready !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got pc=%h v=%b r=%b want pc=00000000 v=0 r=0", pc, pc_valid, redirect_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
        // Redirect presented during BOOT is not accepted.
        step();
        redirect_valid = 1'b0;
        total++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            bad++; $display("FAIL boot_no_redir: got pc=%h v=%b want pc=00000000 v=1", pc, pc_valid);
        end
        step();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL post_reset_adv: got %h want %h", pc, 32'h4); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt_redirect();
        test_redirect_in_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
